axis_rti_chirp_pair_sequencer: RTL and testbench
================================================

# axis_rti_chirp_pair_sequencer

Sequences the up/down chirp buffering for the RTI path. It writes one up-chirp frame and then one down-chirp frame of CORDIC samples into two on-chip bins buffers. It then streams the bin-aligned pairs {down, up} to the RAM writer, one beat per bin, and ends each frame with tlast. The block sits between the CORDIC stage and the RTI RAM/DMA writer, and it applies backpressure to the CORDIC stage while a readout is in progress.

## Interface
- MAG_WIDTH, 16, magnitude field width
- CORDIC_WIDTH, 2*MAG_WIDTH, width of one CORDIC sample (magnitude and phase)
- HALF_FFT_WIDTH, 11, address width; bins buffer depth is 2**HALF_FFT_WIDTH
- TUSER_WIDTH, 16, input tuser width (tuser is ignored; the port exists for bus compatibility)

Ports:
- aclk  in  1  single clock; all logic is on its rising edge
- areset  in  1  synchronous, active-high reset
- cfg_bins  in  4  log2 of bins per chirp
- s_axis_tdata  in  CORDIC_WIDTH  CORDIC sample
- s_axis_tuser  in  TUSER_WIDTH  unused
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last sample of a chirp
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  2*CORDIC_WIDTH  {down_sample, up_sample} for one bin
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last bin of the pair
- m_axis_tready  in  1  output ready
- frame_count  out  16  number of completed readouts; wraps at 2**16
- err_short  out  1  sticky flag: tlast arrived before N samples
- err_long  out  1  sticky flag: more than N samples arrived before tlast

## Operation
- N = 2**min(cfg_bins, HALF_FFT_WIDTH). cfg_bins is latched on every entry to FILL_UP and is held constant for the whole pair.
- States: FILL_UP, FILL_DOWN, READ. Reset enters FILL_UP.
- FILL_UP and FILL_DOWN:
  - s_axis_tready = 1.
  - Each accepted beat with wcnt < N writes ram_u[wcnt] (FILL_UP) or ram_d[wcnt] (FILL_DOWN), then wcnt increments.
  - Beats with wcnt >= N are discarded and set err_long.
  - An accepted tlast with wcnt+1 < N sets err_short. Bins the frame did not write keep stale contents.
  - An accepted tlast clears wcnt to 0 and moves FILL_UP to FILL_DOWN, or FILL_DOWN to READ.
- READ:
  - s_axis_tready = 0.
  - rcnt runs from 0 to N-1. It issues reads of ram_u[rcnt] and ram_d[rcnt] together, and only while an output-buffer credit is free.
  - Read data enters a 2-entry output FIFO. The FIFO head drives m_axis. m_axis_tlast = 1 on the beat for bin N-1.
  - When the tlast beat is accepted: frame_count increments, the state returns to FILL_UP, and cfg_bins is re-latched.
- Error flags clear only on areset.
- Reset at any point:
  - State goes to FILL_UP; wcnt, rcnt, frame_count and the error flags clear; the output FIFO flushes.
  - RAM contents are not cleared.

## Timing
- Reset values: s_axis_tready = 1, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, frame_count = 0, err_short = 0, err_long = 0.
- RAM read latency is 1 cycle.
- Latency:
  - Down-chirp tlast accepted at cycle T: the state is READ at T+1 (addr 0 issued) and RAM data is available at T+2.
  - m_axis_tvalid = 1 at T+3.
- Throughput:
  - With m_axis_tready held high, the block delivers 1 beat/cycle with no bubbles.
  - Under arbitrary backpressure, no beat is lost or duplicated.
  - m_axis_tdata and m_axis_tlast stay stable while tvalid=1 and tready=0.
- s_axis_tready:
  - Drops to 0 in the cycle after the down-chirp tlast is accepted.
  - Returns to 1 in the cycle after the last m_axis beat is accepted.
- N = 1 (cfg_bins = 0): a single-beat frame is legal, and that beat carries tlast.
- A write and a read never address the same RAM in the same cycle, because reads occur only in READ.

## Structure
- Package axis_rti_pkg holds:
  - the state enum (FILL_UP, FILL_DOWN, READ);
  - FIFO_DEPTH = 2;
  - a function that clamps cfg_bins to HALF_FFT_WIDTH.
- Sub-module axis_rti_pair_ram: simple dual-port RAM, CORDIC_WIDTH x 2**HALF_FFT_WIDTH, 1-cycle registered read, block-RAM style. It is instantiated twice, once for up and once for down.
- The output FIFO and credit counter stay inline in the top module.

## Test plan
- Nominal pair: cfg_bins=3, up samples 0x10..0x17, down samples 0x20..0x27, each with tlast on the 8th, tready=1 -> 8 beats {0x20,0x10}..{0x27,0x17}; tlast on beat 8; first tvalid 3 cycles after the down tlast; frame_count=1.
- Random m_axis_tready (50%) over 3 pairs with N=16 -> all 48 beats in order, with no drops or duplicates; held data stays stable; s_axis_tready=0 throughout each READ.
- Short frame: cfg_bins=2, up chirp with tlast on its 3rd sample -> err_short=1; 4 output beats; bin 3 holds the stale up value from the prior pair.
- Long frame: cfg_bins=2, down chirp of 6 samples -> err_long=1; samples 5 and 6 are discarded; the output equals the first 4.
- cfg_bins=15 with HALF_FFT_WIDTH=11 -> N is clamped to 2048; tlast falls on beat 2048.
- areset asserted mid-READ after 3 of 8 beats -> next cycle: m_axis_tvalid=0, s_axis_tready=1, frame_count=0; a fresh pair then streams correctly.

Source files
------------

// File: rtl/axis_rti_pkg.sv
// Shared types and helpers for the RTI up/down chirp pair sequencer.
package axis_rti_pkg;

   typedef enum logic [1:0] {
      ST_FILL_UP   = 2'd0,
      ST_FILL_DOWN = 2'd1,
      ST_READ      = 2'd2
   } state_t;

   localparam int FIFO_DEPTH = 2;

   // Limits the requested log2 bin count to what the buffers can hold.
   function automatic logic [3:0] clamp_bins(input logic [3:0] cfg, input logic [3:0] max_bins);
      return (cfg > max_bins) ? max_bins : cfg;
   endfunction

endpackage

// File: rtl/axis_rti_pair_ram.sv
// Simple dual-port bins buffer with a one-cycle registered read port.
module axis_rti_pair_ram #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 11
) (
   input  logic              aclk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem_r [2**ADDR_W];

   // Write port; contents deliberately survive reset.
   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port.
   always_ff @(posedge aclk) begin
      if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/axis_rti_chirp_pair_sequencer.sv
// Buffers one up-chirp and one down-chirp frame, then streams bin-aligned
// {down, up} pairs with tlast on the final bin.
module axis_rti_chirp_pair_sequencer
   import axis_rti_pkg::*;
#(
   parameter int MAG_WIDTH      = 16,
   parameter int CORDIC_WIDTH   = 2*MAG_WIDTH,
   parameter int HALF_FFT_WIDTH = 11,
   parameter int TUSER_WIDTH    = 16
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [3:0]                cfg_bins,
   input  logic [CORDIC_WIDTH-1:0]   s_axis_tdata,
   input  logic [TUSER_WIDTH-1:0]    s_axis_tuser,
   input  logic                      s_axis_tvalid,
   input  logic                      s_axis_tlast,
   output logic                      s_axis_tready,
   output logic [2*CORDIC_WIDTH-1:0] m_axis_tdata,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_tready,
   output logic [15:0]               frame_count,
   output logic                      err_short,
   output logic                      err_long
);

   localparam int               CNT_W    = HALF_FFT_WIDTH + 1;
   localparam int               OUT_W    = 2*CORDIC_WIDTH;
   localparam logic [3:0]       MAX_BINS = 4'(HALF_FFT_WIDTH);
   localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t                    state_r, state_nxt_s;
   logic [3:0]                bins_r;
   logic [CNT_W-1:0]          n_s, wcnt_r;
   logic [HALF_FFT_WIDTH-1:0] last_addr_s, rcnt_r;
   logic                      rd_done_r, rd_vld_r, rd_last_r;
   logic                      in_fire_s, tlast_fire_s, wr_ok_s, wr_u_s, wr_d_s;
   logic [CORDIC_WIDTH-1:0]   rd_u_s, rd_d_s;
   logic [OUT_W-1:0]          fifo_data_r [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]     fifo_last_r;
   logic                      wptr_r, rptr_r;
   logic [1:0]                fcnt_r, used_s;
   logic                      pop_s, push_s, issue_s, frame_done_s;
   logic                      unused_tuser_s;

   assign unused_tuser_s = ^s_axis_tuser;

   assign n_s         = ONE_CNT << bins_r;
   assign last_addr_s = HALF_FFT_WIDTH'(n_s - ONE_CNT);

   assign s_axis_tready = (state_r != ST_READ);
   assign in_fire_s     = s_axis_tvalid & s_axis_tready;
   assign tlast_fire_s  = in_fire_s & s_axis_tlast;
   assign wr_ok_s       = in_fire_s & (wcnt_r < n_s);
   assign wr_u_s        = wr_ok_s & (state_r == ST_FILL_UP);
   assign wr_d_s        = wr_ok_s & (state_r == ST_FILL_DOWN);

   assign m_axis_tvalid = (fcnt_r != 2'd0);
   assign m_axis_tdata  = fifo_data_r[rptr_r];
   assign m_axis_tlast  = m_axis_tvalid & fifo_last_r[rptr_r];
   assign pop_s         = m_axis_tvalid & m_axis_tready;
   assign push_s        = rd_vld_r;
   assign frame_done_s  = pop_s & m_axis_tlast;

   // A read may issue only if its data is guaranteed a FIFO slot on arrival;
   // counting the same-cycle pop keeps streaming bubble-free.
   assign used_s  = fcnt_r + {1'b0, rd_vld_r};
   assign issue_s = (state_r == ST_READ) & ~rd_done_r & ((used_s < 2'(FIFO_DEPTH)) | pop_s);

   // State register.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r <= ST_FILL_UP;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_FILL_UP:   if (tlast_fire_s) state_nxt_s = ST_FILL_DOWN; else state_nxt_s = ST_FILL_UP;
         ST_FILL_DOWN: if (tlast_fire_s) state_nxt_s = ST_READ;      else state_nxt_s = ST_FILL_DOWN;
         ST_READ:      if (frame_done_s) state_nxt_s = ST_FILL_UP;   else state_nxt_s = ST_READ;
         default:      state_nxt_s = ST_FILL_UP;
      endcase
   end

   // Write counter, frame configuration, sticky errors and frame counter.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wcnt_r      <= {CNT_W{1'b0}};
         bins_r      <= clamp_bins(cfg_bins, MAX_BINS);
         err_short   <= 1'b0;
         err_long    <= 1'b0;
         frame_count <= 16'd0;
      end else begin
         if (tlast_fire_s) begin
            wcnt_r <= {CNT_W{1'b0}};
         end else if (wr_ok_s) begin
            wcnt_r <= wcnt_r + ONE_CNT;
         end
         if (in_fire_s && !wr_ok_s) begin
            err_long <= 1'b1;
         end
         if (tlast_fire_s && ((wcnt_r + ONE_CNT) < n_s)) begin
            err_short <= 1'b1;
         end
         if (frame_done_s) begin
            frame_count <= frame_count + 16'd1;
            bins_r      <= clamp_bins(cfg_bins, MAX_BINS);
         end
      end
   end

   // Read address sequencing and RAM-output valid tracking.
   always_ff @(posedge aclk) begin
      if (areset) begin
         rcnt_r    <= {HALF_FFT_WIDTH{1'b0}};
         rd_done_r <= 1'b0;
         rd_vld_r  <= 1'b0;
         rd_last_r <= 1'b0;
      end else begin
         rd_vld_r  <= issue_s;
         rd_last_r <= issue_s & (rcnt_r == last_addr_s);
         if (frame_done_s) begin
            rcnt_r    <= {HALF_FFT_WIDTH{1'b0}};
            rd_done_r <= 1'b0;
         end else if (issue_s) begin
            if (rcnt_r == last_addr_s) begin
               rd_done_r <= 1'b1;
            end else begin
               rcnt_r <= rcnt_r + {{(HALF_FFT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   // Two-entry output FIFO; its head drives the master stream.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wptr_r      <= 1'b0;
         rptr_r      <= 1'b0;
         fcnt_r      <= 2'd0;
         fifo_last_r <= {FIFO_DEPTH{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_r[i] <= {OUT_W{1'b0}};
         end
      end else begin
         if (push_s) begin
            fifo_data_r[wptr_r] <= {rd_d_s, rd_u_s};
            fifo_last_r[wptr_r] <= rd_last_r;
            wptr_r              <= ~wptr_r;
         end
         if (pop_s) begin
            rptr_r <= ~rptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   fcnt_r <= fcnt_r + 2'd1;
            2'b01:   fcnt_r <= fcnt_r - 2'd1;
            default: fcnt_r <= fcnt_r;
         endcase
      end
   end

   axis_rti_pair_ram #(.WIDTH(CORDIC_WIDTH), .ADDR_W(HALF_FFT_WIDTH)) u_ram_up (
      .aclk    (aclk),
      .wr_en   (wr_u_s),
      .wr_addr (wcnt_r[HALF_FFT_WIDTH-1:0]),
      .wr_data (s_axis_tdata),
      .rd_en   (issue_s),
      .rd_addr (rcnt_r),
      .rd_data (rd_u_s)
   );

   axis_rti_pair_ram #(.WIDTH(CORDIC_WIDTH), .ADDR_W(HALF_FFT_WIDTH)) u_ram_down (
      .aclk    (aclk),
      .wr_en   (wr_d_s),
      .wr_addr (wcnt_r[HALF_FFT_WIDTH-1:0]),
      .wr_data (s_axis_tdata),
      .rd_en   (issue_s),
      .rd_addr (rcnt_r),
      .rd_data (rd_d_s)
   );

endmodule

// File: tb/tb_axis_rti_chirp_pair_sequencer.sv
// Scoreboard bench: stimulus pushes expected {down, up} beats, a monitor pops and compares.
module tb_axis_rti_chirp_pair_sequencer;

   logic        aclk = 1'b0;
   logic        areset;
   logic [3:0]  cfg_bins;
   logic [31:0] s_axis_tdata;
   logic [15:0] s_axis_tuser;
   logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic [15:0] frame_count;
   logic        err_short, err_long;

   typedef struct packed {
      logic [63:0] d;
      logic        l;
   } exp_t;

   exp_t        exp_q[$];
   int          tests_run = 0;
   int          tests_failed = 0;
   int          beats_seen = 0;
   logic        rand_mode = 1'b0;
   logic [31:0] mu [0:2047];
   logic [31:0] md [0:2047];

   axis_rti_chirp_pair_sequencer dut (
      .aclk          (aclk),
      .areset        (areset),
      .cfg_bins      (cfg_bins),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .frame_count   (frame_count),
      .err_short     (err_short),
      .err_long      (err_long)
   );

   initial forever #5 aclk = ~aclk;

   // Output-side ready: always high, or a coin flip per cycle in random mode.
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: compares accepted beats with the scoreboard and checks hold stability.
   initial begin
      logic        held_v;
      logic [63:0] held_d;
      logic        held_l;
      exp_t        e;
      held_v = 1'b0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            held_v = 1'b0;
         end else begin
            if (held_v) begin
               tests_run++;
               if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_d || m_axis_tlast !== held_l) begin
                  tests_failed++;
                  $display("FAIL hold_stable: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                           m_axis_tvalid, m_axis_tdata, m_axis_tlast, held_d, held_l);
               end
            end
            if (m_axis_tvalid === 1'b1) begin
               tests_run++;
               if (s_axis_tready !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL in_ready_during_read: got %b required 0", s_axis_tready);
               end
               if (m_axis_tready) begin
                  beats_seen++;
                  tests_run++;
                  if (exp_q.size() == 0) begin
                     tests_failed++;
                     $display("FAIL unexpected_beat: got d=%h l=%b required no beat", m_axis_tdata, m_axis_tlast);
                  end else begin
                     e = exp_q.pop_front();
                     if (m_axis_tdata !== e.d || m_axis_tlast !== e.l) begin
                        tests_failed++;
                        $display("FAIL beat: got d=%h l=%b required d=%h l=%b",
                                 m_axis_tdata, m_axis_tlast, e.d, e.l);
                     end
                  end
                  held_v = 1'b0;
               end else begin
                  held_v = 1'b1;
                  held_d = m_axis_tdata;
                  held_l = m_axis_tlast;
               end
            end else begin
               held_v = 1'b0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic beat(input logic [31:0] d, input logic last);
      int w;
      w = 0;
      while (s_axis_tready !== 1'b1 && w < 5000) begin
         @(posedge aclk);
         #1;
         w++;
      end
      if (w >= 5000) begin
         check("in_ready_timeout", 64'(w), 64'd0);
      end
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   // Sends a chirp and records into the reference buffers what should be kept.
   task automatic chirp(input bit down, input logic [31:0] base, input int count, input int n);
      int   wc;
      logic l;
      wc = 0;
      for (int i = 0; i < count; i++) begin
         l = (i == count - 1);
         if (wc < n) begin
            if (down) md[wc] = base + 32'(i);
            else      mu[wc] = base + 32'(i);
            wc++;
         end
         beat(base + 32'(i), l);
      end
   endtask

   task automatic push_model(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.d = {md[i], mu[i]};
         e.l = (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain(input string name);
      int w;
      w = 0;
      while (!(exp_q.size() == 0 && s_axis_tready === 1'b1 && m_axis_tvalid === 1'b0) && w < 20000) begin
         @(posedge aclk);
         #1;
         w++;
      end
      tests_run++;
      if (w >= 20000) begin
         tests_failed++;
         $display("FAIL %s_drain_timeout: got %0d beats pending required 0", name, exp_q.size());
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   bs0;
      int   w;
      areset        = 1'b1;
      cfg_bins      = 4'd3;
      s_axis_tdata  = 32'd0;
      s_axis_tuser  = 16'hBEEF;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      check("rst_in_ready", 64'(s_axis_tready), 64'd1);
      check("rst_out_valid", 64'(m_axis_tvalid), 64'd0);
      check("rst_out_last", 64'(m_axis_tlast), 64'd0);
      check("rst_out_data", m_axis_tdata, 64'd0);
      check("rst_frame_count", 64'(frame_count), 64'd0);
      check("rst_errs", 64'({err_short, err_long}), 64'd0);
      areset = 1'b0;
      @(posedge aclk);
      #1;

      // Nominal pair, N=8, hand-computed expectations.
      chirp(1'b0, 32'h10, 8, 8);
      chirp(1'b1, 32'h20, 8, 8);
      for (int i = 0; i < 8; i++) begin
         e.d = {32'h20 + 32'(i), 32'h10 + 32'(i)};
         e.l = (i == 7);
         exp_q.push_back(e);
      end
      cfg_bins = 4'd4;
      check("nom_in_ready_drop", 64'(s_axis_tready), 64'd0);
      check("nom_valid_t1", 64'(m_axis_tvalid), 64'd0);
      @(posedge aclk);
      #1;
      check("nom_valid_t2", 64'(m_axis_tvalid), 64'd0);
      @(posedge aclk);
      #1;
      check("nom_valid_t3", 64'(m_axis_tvalid), 64'd1);
      wait_drain("nom");
      check("nom_frame_count", 64'(frame_count), 64'd1);
      check("nom_errs", 64'({err_short, err_long}), 64'd0);

      // Three N=16 pairs under random backpressure.
      rand_mode = 1'b1;
      for (int p = 0; p < 3; p++) begin
         chirp(1'b0, 32'h1000 * 32'(p + 1) + 32'h100, 16, 16);
         chirp(1'b1, 32'h1000 * 32'(p + 1) + 32'h200, 16, 16);
         push_model(16);
         if (p == 2) cfg_bins = 4'd2;
         wait_drain("rand");
      end
      rand_mode = 1'b0;
      check("rand_frame_count", 64'(frame_count), 64'd4);

      // Short up chirp, N=4: bin 3 keeps the previous up value.
      chirp(1'b0, 32'h500, 3, 4);
      chirp(1'b1, 32'h600, 4, 4);
      push_model(4);
      wait_drain("short");
      check("short_err_short", 64'(err_short), 64'd1);
      check("short_err_long", 64'(err_long), 64'd0);
      check("short_frame_count", 64'(frame_count), 64'd5);

      // Long down chirp, N=4, samples 5 and 6 dropped.
      chirp(1'b0, 32'h700, 4, 4);
      chirp(1'b1, 32'h800, 6, 4);
      push_model(4);
      cfg_bins = 4'd15;
      wait_drain("long");
      check("long_err_long", 64'(err_long), 64'd1);
      check("long_err_short_sticky", 64'(err_short), 64'd1);
      check("long_frame_count", 64'(frame_count), 64'd6);

      // cfg_bins=15 clamps to 2048 bins.
      chirp(1'b0, 32'h10000, 2048, 2048);
      chirp(1'b1, 32'h20000, 2048, 2048);
      push_model(2048);
      cfg_bins = 4'd3;
      wait_drain("clamp");
      check("clamp_frame_count", 64'(frame_count), 64'd7);

      // Reset in the middle of a readout after 3 of 8 beats.
      chirp(1'b0, 32'hA00, 8, 8);
      chirp(1'b1, 32'hB00, 8, 8);
      bs0 = beats_seen;
      push_model(8);
      w = 0;
      while (beats_seen < bs0 + 3 && w < 200) begin
         @(posedge aclk);
         #1;
         w++;
      end
      check("mid_reset_beats", 64'(beats_seen - bs0), 64'd3);
      areset = 1'b1;
      exp_q.delete();
      @(posedge aclk);
      #1;
      check("mid_reset_out_valid", 64'(m_axis_tvalid), 64'd0);
      check("mid_reset_in_ready", 64'(s_axis_tready), 64'd1);
      check("mid_reset_frame_count", 64'(frame_count), 64'd0);
      check("mid_reset_errs", 64'({err_short, err_long}), 64'd0);
      areset = 1'b0;
      @(posedge aclk);
      #1;
      chirp(1'b0, 32'hC00, 8, 8);
      chirp(1'b1, 32'hD00, 8, 8);
      push_model(8);
      wait_drain("fresh");
      check("fresh_frame_count", 64'(frame_count), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
